// File: rtl/line_pingpong_buf.sv
// line_pingpong_buf
//   Ping-pong line buffer that feeds the Gaussian filter. Incoming raster pixels
//   are written alternately into two line banks. When a line is complete it is
//   burst out, one pixel per clock, on the port pair of the bank that holds it,
//   while the next line fills the other bank.
//
// Ports
//   clk            clock, everything on the rising edge
//   rst_n          asynchronous active-low reset
//   sof_in         start of frame, meaningful only together with pix_valid_in
//   pix_valid_in   input pixel strobe
//   pix_data_in    input pixel
//   ram0_valid_in  bank-0 readout beat valid
//   ram0_data_in   bank-0 readout pixel, zero when not valid
//   ram1_valid_in  bank-1 readout beat valid
//   ram1_data_in   bank-1 readout pixel, zero when not valid
//   line_done      one-cycle pulse on the last readout beat of a line
//   frame_done     one-cycle pulse on the last readout beat of the last frame line
//   line_cnt       lines fully read out in the current frame
//   sof_abort      sticky flag: a start of frame arrived while a frame was filling
module line_pingpong_buf #(
  parameter int DATA_W  = 8,
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 8,
  parameter int FRAME_H = 256,
  parameter int LCNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof_in,
  input  logic              pix_valid_in,
  input  logic [DATA_W-1:0] pix_data_in,
  output logic              ram0_valid_in,
  output logic [DATA_W-1:0] ram0_data_in,
  output logic              ram1_valid_in,
  output logic [DATA_W-1:0] ram1_data_in,
  output logic              line_done,
  output logic              frame_done,
  output logic [LCNT_W-1:0] line_cnt,
  output logic              sof_abort
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_FILL = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_W - 1);
  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(FRAME_H - 1);

  logic [DATA_W-1:0] mem0 [0:LINE_W-1];
  logic [DATA_W-1:0] mem1 [0:LINE_W-1];

  logic [0:0]        w_state;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [LCNT_W-1:0] lines_wr;

  logic [0:0]        r_state;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;

  logic              p1_valid;
  logic              p1_bank;
  logic              p1_last;
  logic [DATA_W-1:0] ram_q;

  logic              sof_beat;
  logic              fill_beat;
  logic              swap;
  logic              wr_en;
  logic              wr_sel_bank;
  logic [ADDR_W-1:0] wr_sel_addr;
  logic              abort_all;
  logic              abort_b0;
  logic              kill_rd;
  logic              kill_p1;
  logic              beat_out;

  assign sof_beat  = pix_valid_in & sof_in;
  assign fill_beat = pix_valid_in & ~sof_in & (w_state == W_FILL);
  assign swap      = fill_beat & (wr_addr == LAST_ADDR);

  // A start-of-frame pixel always lands at address 0 of bank 0.
  assign wr_en       = sof_beat | fill_beat;
  assign wr_sel_bank = sof_beat ? 1'b0 : wr_bank;
  assign wr_sel_addr = sof_beat ? '0 : wr_addr;

  // A restart mid-frame throws away every readout in flight. A start of frame
  // after a finished frame only clobbers bank 0, so only bank-0 readout dies.
  assign abort_all = sof_beat & (w_state == W_FILL);
  assign abort_b0  = sof_beat & (w_state == W_IDLE);
  assign kill_rd   = abort_all | (abort_b0 & ~rd_bank);
  assign kill_p1   = abort_all | (abort_b0 & ~p1_bank);
  assign beat_out  = p1_valid & ~kill_p1;

  // Write side: line fill, bank toggling and frame line counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      lines_wr  <= '0;
      sof_abort <= 1'b0;
    end else if (sof_beat) begin
      if (w_state == W_FILL) begin
        sof_abort <= 1'b1;
      end
      w_state  <= W_FILL;
      wr_bank  <= 1'b0;
      wr_addr  <= ADDR_W'(1);
      lines_wr <= '0;
    end else if (fill_beat) begin
      if (wr_addr == LAST_ADDR) begin
        wr_addr  <= '0;
        wr_bank  <= ~wr_bank;
        lines_wr <= lines_wr + LCNT_W'(1);
        if (lines_wr == LAST_LINE) begin
          w_state <= W_IDLE;
        end
      end else begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

  // Line banks: plain write port plus a registered read of the bank being drained.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_sel_bank) begin
      mem0[wr_sel_addr] <= pix_data_in;
    end
    if (wr_en && wr_sel_bank) begin
      mem1[wr_sel_addr] <= pix_data_in;
    end
    ram_q <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

  // Read side: a swap may land on the final address of the previous burst, in
  // which case the new burst starts right behind it with no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
    end else if (swap) begin
      r_state <= R_RUN;
      rd_bank <= wr_bank;
      rd_addr <= '0;
    end else if (r_state == R_RUN) begin
      if (kill_rd || rd_addr == LAST_ADDR) begin
        r_state <= R_IDLE;
        rd_addr <= '0;
      end else begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

  // Side-band tags that travel alongside the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_bank  <= 1'b0;
      p1_last  <= 1'b0;
    end else begin
      p1_valid <= (r_state == R_RUN) & ~kill_rd;
      p1_bank  <= rd_bank;
      p1_last  <= (rd_addr == LAST_ADDR);
    end
  end

  // Output registers. An aborted burst never produces line_done because its
  // last beat is killed before it reaches this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram0_valid_in <= 1'b0;
      ram0_data_in  <= '0;
      ram1_valid_in <= 1'b0;
      ram1_data_in  <= '0;
      line_done     <= 1'b0;
      frame_done    <= 1'b0;
      line_cnt      <= '0;
    end else begin
      ram0_valid_in <= beat_out & ~p1_bank;
      ram0_data_in  <= (beat_out & ~p1_bank) ? ram_q : '0;
      ram1_valid_in <= beat_out & p1_bank;
      ram1_data_in  <= (beat_out & p1_bank) ? ram_q : '0;
      line_done     <= beat_out & p1_last;
      frame_done    <= beat_out & p1_last & (line_cnt == LAST_LINE);
      if (sof_beat) begin
        line_cnt <= '0;
      end else if (beat_out && p1_last) begin
        line_cnt <= line_cnt + LCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_pingpong_buf.sv
// tb_line_pingpong_buf
//   Directed bench for line_pingpong_buf with 8-pixel lines and 4-line frames.
//   A monitor logs every readout beat (bank, pixel, clock edge that produced it)
//   and the directed steps compare that log with hand-derived expectations.
module tb_line_pingpong_buf;

  localparam int DATA_W  = 8;
  localparam int LINE_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int FRAME_H = 4;
  localparam int LCNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sof_in = 1'b0;
  logic              pix_valid_in = 1'b0;
  logic [DATA_W-1:0] pix_data_in = '0;
  logic              ram0_valid_in;
  logic [DATA_W-1:0] ram0_data_in;
  logic              ram1_valid_in;
  logic [DATA_W-1:0] ram1_data_in;
  logic              line_done;
  logic              frame_done;
  logic [LCNT_W-1:0] line_cnt;
  logic              sof_abort;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;
  int q_bank[$];
  int q_data[$];
  int q_edge[$];
  int n_line_done = 0;
  int n_frame_done = 0;
  int last_ld_edge = -1;
  int last_fd_edge = -1;
  int excl_viol = 0;
  int idle_data_viol = 0;
  int lw;
  int lw2;
  int found;

  line_pingpong_buf #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W),
    .FRAME_H(FRAME_H),
    .LCNT_W (LCNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sof_in       (sof_in),
    .pix_valid_in (pix_valid_in),
    .pix_data_in  (pix_data_in),
    .ram0_valid_in(ram0_valid_in),
    .ram0_data_in (ram0_data_in),
    .ram1_valid_in(ram1_valid_in),
    .ram1_data_in (ram1_data_in),
    .line_done    (line_done),
    .frame_done   (frame_done),
    .line_cnt     (line_cnt),
    .sof_abort    (sof_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat logger; cyc here is the index of the edge that produced the outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(ram0_valid_in && ram1_valid_in))
      else begin
        excl_viol++;
        $error("[TB] FAIL exclusivity: both valids high at edge %0d", cyc);
      end
      if (!ram0_valid_in && ram0_data_in != '0) idle_data_viol++;
      if (!ram1_valid_in && ram1_data_in != '0) idle_data_viol++;
      if (ram0_valid_in) begin
        q_bank.push_back(0);
        q_data.push_back(int'(ram0_data_in));
        q_edge.push_back(cyc);
      end
      if (ram1_valid_in) begin
        q_bank.push_back(1);
        q_data.push_back(int'(ram1_data_in));
        q_edge.push_back(cyc);
      end
      if (line_done) begin
        n_line_done++;
        last_ld_edge = cyc;
      end
      if (frame_done) begin
        n_frame_done++;
        last_fd_edge = cyc;
      end
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Drive one input cycle; returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input bit v, input bit s, input int d);
    pix_valid_in = v;
    sof_in       = s;
    pix_data_in  = d[DATA_W-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0);
  endtask

  task automatic sendLine(input bit with_sof, input int base, input int gap);
    for (int i = 0; i < LINE_W; i++) begin
      applyStimulus(1'b1, with_sof && (i == 0), base + i);
      idleCycles(gap);
    end
  endtask

  task automatic clearLog();
    q_bank.delete();
    q_data.delete();
    q_edge.delete();
    n_line_done  = 0;
    n_frame_done = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(1);
    clearLog();
  endtask

  // One contiguous burst: bank, pixel base+i, and edge edge0+i for each beat.
  task automatic checkBurst(input string tag, input int first, input int n,
                            input int bank, input int base, input int edge0);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_bank"}, qget(q_bank, first + i), bank);
      checkOutput({tag, "_data"}, qget(q_data, first + i), base + i);
      checkOutput({tag, "_edge"}, qget(q_edge, first + i), edge0 + i);
    end
  endtask

  initial begin
    #3;
    checkOutput("rst_ram0_valid", int'(ram0_valid_in), 0);
    checkOutput("rst_ram1_valid", int'(ram1_valid_in), 0);
    checkOutput("rst_line_done",  int'(line_done), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_line_cnt",   int'(line_cnt), 0);
    checkOutput("rst_sof_abort",  int'(sof_abort), 0);

    // single line, full rate
    doReset();
    sendLine(1'b1, 0, 0);
    lw = cyc;
    idleCycles(12);
    checkOutput("t1_beats", q_bank.size(), 8);
    checkBurst("t1", 0, 8, 0, 0, lw + 2);
    checkOutput("t1_line_done_n", n_line_done, 1);
    checkOutput("t1_line_done_edge", last_ld_edge, lw + 9);
    checkOutput("t1_frame_done_n", n_frame_done, 0);
    checkOutput("t1_line_cnt", int'(line_cnt), 1);

    // full frame at full rate, then pixels without sof
    doReset();
    sendLine(1'b1, 0, 0);
    lw = cyc;
    sendLine(1'b0, 16, 0);
    sendLine(1'b0, 32, 0);
    sendLine(1'b0, 48, 0);
    sendLine(1'b0, 96, 0);
    idleCycles(12);
    checkOutput("t2_beats", q_bank.size(), 32);
    for (int k = 0; k < 4; k++) checkBurst("t2", 8 * k, 8, k % 2, 16 * k, lw + 2 + 8 * k);
    checkOutput("t2_line_done_n", n_line_done, 4);
    checkOutput("t2_frame_done_n", n_frame_done, 1);
    checkOutput("t2_frame_done_edge", last_fd_edge, lw + 33);
    checkOutput("t2_line_cnt", int'(line_cnt), 4);
    checkOutput("t2_sof_abort", int'(sof_abort), 0);

    // one-in-three input duty, new frame after a finished one
    clearLog();
    sendLine(1'b1, 64, 2);
    lw = cyc - 2;
    sendLine(1'b0, 72, 2);
    lw2 = cyc - 2;
    idleCycles(12);
    checkOutput("t3_beats", q_bank.size(), 16);
    checkBurst("t3a", 0, 8, 0, 64, lw + 2);
    checkBurst("t3b", 8, 8, 1, 72, lw2 + 2);
    checkOutput("t3_line_cnt", int'(line_cnt), 2);
    checkOutput("t3_sof_abort", int'(sof_abort), 0);

    // start of frame at beat 5 of line 2 kills the line-1 burst in flight
    doReset();
    sendLine(1'b1, 128, 0);
    lw = cyc;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 144 + i);
    checkOutput("t4_abort_before", int'(sof_abort), 0);
    sendLine(1'b1, 160, 0);
    lw2 = cyc;
    checkOutput("t4_line_cnt_restart", int'(line_cnt), 0);
    idleCycles(12);
    checkOutput("t4_sof_abort", int'(sof_abort), 1);
    checkOutput("t4_beats", q_bank.size(), 11);
    checkBurst("t4old", 0, 3, 0, 128, lw + 2);
    checkBurst("t4new", 3, 8, 0, 160, lw2 + 2);
    checkOutput("t4_line_done_n", n_line_done, 1);
    checkOutput("t4_line_cnt", int'(line_cnt), 1);

    // reset asserted during a bank-1 burst
    doReset();
    sendLine(1'b1, 0, 0);
    sendLine(1'b0, 8, 0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      idleCycles(1);
      if (ram1_valid_in) found = 1;
    end
    checkOutput("t5_ram1_burst_seen", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_ram0_valid", int'(ram0_valid_in), 0);
    checkOutput("t5_ram1_valid", int'(ram1_valid_in), 0);
    checkOutput("t5_ram1_data",  int'(ram1_data_in), 0);
    checkOutput("t5_line_done",  int'(line_done), 0);
    checkOutput("t5_line_cnt",   int'(line_cnt), 0);
    checkOutput("t5_sof_abort",  int'(sof_abort), 0);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(1);
    clearLog();
    sendLine(1'b1, 200, 0);
    lw = cyc;
    idleCycles(12);
    checkOutput("t5_beats", q_bank.size(), 8);
    checkBurst("t5", 0, 8, 0, 200, lw + 2);
    checkOutput("t5_line_cnt_after", int'(line_cnt), 1);

    checkOutput("exclusive_valids", excl_viol, 0);
    checkOutput("idle_data_zero", idle_data_viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
